uart_rx_core: RTL and testbench
===============================

// Module: uart_rx_core
// PURPOSE
//  Parametrised UART receiver with oversampled start/data/stop detection and a show-ahead receive FIFO.
//  Supports 5..DATA_W data bits and optional parity. Stores per-frame error flags with each word.
//  Sits between the rx pin and the uart_ip status/read register path; pairs with the existing transmitter.
// PARAMETERS
//  DATA_W   8   maximum data bits per frame (>=5)
//  OVS      16  oversample ticks per bit (even, >=8)
//  DEPTH    8   receive FIFO entries (power of 2, >=2)
//  DIV_W    16  width of baud divider
// PORTS
//  clk            in   1                   system clock
//  arst_n         in   1                   asynchronous active-low reset
//  rx             in   1                   serial input, asynchronous to clk, idle high
//  cfg_en         in   1                   receiver enable; 0 forces IDLE, FIFO retained
//  cfg_baud_div   in   DIV_W               oversample tick every cfg_baud_div+1 clk cycles
//  cfg_nbits      in   $clog2(DATA_W+1)    data bits per frame; <5 or >DATA_W treated as DATA_W
//  cfg_parity_en  in   1                   parity bit present (UART_RX_PARITY_EN only)
//  cfg_parity_odd in   1                   1=odd, 0=even parity (UART_RX_PARITY_EN only)
//  rd_en          in   1                   pop FIFO head; ignored when empty
//  rd_valid       out  1                   FIFO not empty
//  rd_data        out  DATA_W              head word, LSB-first assembled, unused MSBs 0
//  rd_frame_err   out  1                   head word had stop bit sampled low
//  rd_parity_err  out  1                   head word failed parity check
//  fifo_level     out  $clog2(DEPTH)+1     entries held, 0..DEPTH
//  overrun        out  1                   sticky: frame completed while FIFO full
//  ovr_clr        in   1                   clears overrun (set wins if simultaneous)
//  busy           out  1                   FSM not in IDLE
// BEHAVIOUR
//  - Reset: all outputs 0, FIFO empty, FSM IDLE, rx synchroniser flops = 1, tick counter 0.
//  - rx passes a 2-flop synchroniser; all decisions use synchronised value.
//  - Tick counter runs only when busy; free divider reloads on start edge so sampling is phase-aligned.
//  - FSM: IDLE -> START on synchronised 1->0 with cfg_en=1. START: at tick OVS/2-1 sample; 1 = glitch -> IDLE, 0 -> DATA.
//  - DATA: sample at mid-bit every OVS ticks, shift LSB first, cfg_nbits bits -> PARITY if enabled, else STOP.
//  - PARITY: sample; error if XOR(data,bit) != cfg_parity_odd. STOP: sample at mid-bit; 0 sets frame_err.
//  - STOP mid-sample -> push {parity_err,frame_err,data} on next clk, FSM -> IDLE same cycle (half stop bit tolerated).
//  - Latency: word visible on rd_valid/rd_data 1 clk after stop mid-sample.
//  - cfg_* sampled at start-edge detection and held for the frame; changes mid-frame take effect next frame.
//  - cfg_en deassert mid-frame: FSM -> IDLE next clk, partial frame discarded, no push.
//  - FIFO full at push: word dropped, overrun set; if rd_en same cycle, pop and push both occur, no overrun.
//  - Empty with rd_en: no change, no error. fifo_level updates 1 clk after push/pop; pointers wrap mod DEPTH.
//  - Break (rx low through stop): frame_err word pushed; FSM waits in IDLE for rx high before next start.
//  - arst_n assert mid-frame: immediate return to reset state, FIFO contents lost.
// CONFIGURATION
//  - UART_RX_PARITY_EN defined: PARITY state built; cfg_parity_en/cfg_parity_odd honoured; rd_parity_err live.
//  - Not defined: no PARITY state; parity ports present but ignored; rd_parity_err tied 0; FIFO entry is DATA_W+1 wide.
// STRUCTURE
//  - uart_pkg: rx FSM state enum (IDLE,START,DATA,PARITY,STOP), rx_entry_t struct {parity_err,frame_err,data}, OVS/DEPTH defaults.
//  - Sub-module uart_rx_fifo: synchronous show-ahead FIFO of rx_entry_t with level, full, empty; top holds sync, divider, FSM.
// TESTING
//  - Set OVS=16, cfg_baud_div=3 (64 clk/bit), 8N1. Send 0xA5 -> rd_valid 1 clk after stop mid-sample; rd_data=0xA5, errors 0.
//  - cfg_nbits=5, send 0x1F then 0x15 -> two entries 0x1F, 0x15, upper bits 0, fifo_level=2.
//  - Parity odd, send 0x03 with parity bit 1 -> parity_err 0; with parity bit 0 -> parity_err 1 (macro defined).
//  - Stop bit driven low -> rd_frame_err=1; 20-clk low glitch on idle rx -> no push, busy returns 0.
//  - DEPTH=8: send 9 frames, no reads -> fifo_level=8, overrun=1, head=frame 1; ovr_clr -> overrun=0.
//  - Assert arst_n mid-DATA, release, send 0x3C -> only 0x3C received; deassert cfg_en mid-frame -> no push.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receiver slice: FSM state encoding,
// the receive-FIFO entry layout and default sizing constants.
package uart_pkg;

  localparam int UART_DATA_W = 8;
  localparam int UART_OVS    = 16;
  localparam int UART_DEPTH  = 8;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_e;

  // Entry layout at the default data width; the core packs the same field order.
  typedef struct packed {
    logic                   parity_err;
    logic                   frame_err;
    logic [UART_DATA_W-1:0] data;
  } rx_entry_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO: head entry is presented combinationally from storage,
// push/pop are synchronous, a pop on empty and a push on full (without pop) are ignored.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int W     = UART_DATA_W + 2,
  parameter int DEPTH = UART_DEPTH
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push_s, do_pop_s;

  assign empty     = (level_q == {LW{1'b0}});
  assign full      = (level_q == LW'(DEPTH));
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);
  assign level     = level_q;

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    if (empty) begin
      rdata = {W{1'b0}};
    end else begin
      rdata = mem_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      level_q  <= {LW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver: rx synchroniser, phase-aligned baud divider, frame FSM
// and a show-ahead receive FIFO. Define UART_RX_PARITY_EN to build the parity stage.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int OVS    = UART_OVS,
  parameter int DEPTH  = UART_DEPTH,
  parameter int DIV_W  = 16
) (
  input  logic                        clk,
  input  logic                        arst_n,
  input  logic                        rx,
  input  logic                        cfg_en,
  input  logic [DIV_W-1:0]            cfg_baud_div,
  input  logic [$clog2(DATA_W+1)-1:0] cfg_nbits,
  input  logic                        cfg_parity_en,
  input  logic                        cfg_parity_odd,
  input  logic                        rd_en,
  output logic                        rd_valid,
  output logic [DATA_W-1:0]           rd_data,
  output logic                        rd_frame_err,
  output logic                        rd_parity_err,
  output logic [$clog2(DEPTH):0]      fifo_level,
  output logic                        overrun,
  input  logic                        ovr_clr,
  output logic                        busy
);

  localparam int NB_W = $clog2(DATA_W + 1);
  localparam int TW   = $clog2(OVS);
`ifdef UART_RX_PARITY_EN
  localparam int ENTRY_W = DATA_W + 2;
`else
  localparam int ENTRY_W = DATA_W + 1;
`endif
  localparam logic [TW-1:0] HALF_TICK = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] FULL_TICK = TW'(OVS - 1);

  function automatic logic parity_of(input logic [DATA_W-1:0] d);
    parity_of = ^d;
  endfunction

  rx_state_e         state_q, state_d;
  logic              rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d, baud_div_q, baud_div_d;
  logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
  logic [NB_W-1:0]   bit_cnt_q, bit_cnt_d, nbits_q, nbits_d, nbits_eff_s;
  logic [DATA_W-1:0] data_q, data_d;
  logic              ovr_q, ovr_d;
  logic              start_edge_s, tick_s, mid_s, last_bit_s, push_s;
  logic [ENTRY_W-1:0] wr_entry_s, rd_entry_s;
  logic              fifo_full_s, fifo_empty_s;
`ifdef UART_RX_PARITY_EN
  logic              par_en_q, par_en_d, par_odd_q, par_odd_d, par_err_q, par_err_d;
`else
  logic              unused_parity_s;
  assign unused_parity_s = cfg_parity_en ^ cfg_parity_odd;
`endif

  assign busy         = (state_q != RX_IDLE);
  assign start_edge_s = cfg_en && rx_prev_q && !rx_s2_q;
  assign tick_s       = busy && (div_cnt_q == baud_div_q);
  assign mid_s        = tick_s && (tick_cnt_q == ((state_q == RX_START) ? HALF_TICK : FULL_TICK));
  assign last_bit_s   = (bit_cnt_q == (nbits_q - NB_W'(1)));
  assign nbits_eff_s  = ((cfg_nbits < NB_W'(5)) || (cfg_nbits > NB_W'(DATA_W))) ? NB_W'(DATA_W) : cfg_nbits;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= RX_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: disabling the receiver abandons any frame in flight.
  always_comb begin
    state_d = state_q;
    if (!cfg_en) begin
      state_d = RX_IDLE;
    end else begin
      case (state_q)
        RX_IDLE: begin
          if (start_edge_s) state_d = RX_START;
          else              state_d = RX_IDLE;
        end
        RX_START: begin
          if (mid_s) state_d = rx_s2_q ? RX_IDLE : RX_DATA;
          else       state_d = RX_START;
        end
        RX_DATA: begin
          if (mid_s && last_bit_s) begin
`ifdef UART_RX_PARITY_EN
            if (par_en_q) state_d = RX_PARITY;
            else          state_d = RX_STOP;
`else
            state_d = RX_STOP;
`endif
          end else begin
            state_d = RX_DATA;
          end
        end
`ifdef UART_RX_PARITY_EN
        RX_PARITY: begin
          if (mid_s) state_d = RX_STOP;
          else       state_d = RX_PARITY;
        end
`endif
        RX_STOP: begin
          if (mid_s) state_d = RX_IDLE;
          else       state_d = RX_STOP;
        end
        default: state_d = RX_IDLE;
      endcase
    end
  end

  // Datapath: synchroniser, divider, bit assembly, frame config capture and FIFO push.
  always_comb begin
    rx_s1_d    = rx;
    rx_s2_d    = rx_s1_q;
    rx_prev_d  = rx_s2_q;
    div_cnt_d  = div_cnt_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    data_d     = data_q;
    baud_div_d = baud_div_q;
    nbits_d    = nbits_q;
    push_s     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
    par_err_d  = par_err_q;
`endif
    if (state_q == RX_IDLE) begin
      div_cnt_d  = {DIV_W{1'b0}};
      tick_cnt_d = {TW{1'b0}};
      if (start_edge_s) begin
        baud_div_d = cfg_baud_div;
        nbits_d    = nbits_eff_s;
        bit_cnt_d  = {NB_W{1'b0}};
        data_d     = {DATA_W{1'b0}};
`ifdef UART_RX_PARITY_EN
        par_en_d   = cfg_parity_en;
        par_odd_d  = cfg_parity_odd;
        par_err_d  = 1'b0;
`endif
      end else begin
        baud_div_d = baud_div_q;
      end
    end else begin
      if (tick_s) begin
        div_cnt_d  = {DIV_W{1'b0}};
        tick_cnt_d = mid_s ? {TW{1'b0}} : (tick_cnt_q + TW'(1));
      end else begin
        div_cnt_d  = div_cnt_q + DIV_W'(1);
      end
      case (state_q)
        RX_DATA: begin
          if (mid_s) begin
            data_d    = data_q | (DATA_W'(rx_s2_q) << bit_cnt_q);
            bit_cnt_d = bit_cnt_q + NB_W'(1);
          end else begin
            data_d    = data_q;
          end
        end
`ifdef UART_RX_PARITY_EN
        RX_PARITY: begin
          if (mid_s) par_err_d = ((parity_of(data_q) ^ rx_s2_q) != par_odd_q);
          else       par_err_d = par_err_q;
        end
`endif
        RX_STOP: begin
          if (mid_s) push_s = cfg_en;
          else       push_s = 1'b0;
        end
        default: push_s = 1'b0;
      endcase
    end
  end

`ifdef UART_RX_PARITY_EN
  assign wr_entry_s    = {par_err_q, ~rx_s2_q, data_q};
  assign rd_parity_err = rd_entry_s[DATA_W+1];
`else
  assign wr_entry_s    = {~rx_s2_q, data_q};
  assign rd_parity_err = 1'b0;
`endif
  assign rd_frame_err = rd_entry_s[DATA_W];
  assign rd_data      = rd_entry_s[DATA_W-1:0];
  assign rd_valid     = !fifo_empty_s;
  assign overrun      = ovr_q;

  // A completed frame that finds the FIFO full is lost; a set beats a simultaneous clear.
  always_comb begin
    if (push_s && fifo_full_s && !rd_en) begin
      ovr_d = 1'b1;
    end else if (ovr_clr) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      div_cnt_q  <= {DIV_W{1'b0}};
      tick_cnt_q <= {TW{1'b0}};
      bit_cnt_q  <= {NB_W{1'b0}};
      data_q     <= {DATA_W{1'b0}};
      baud_div_q <= {DIV_W{1'b0}};
      nbits_q    <= {NB_W{1'b0}};
      ovr_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      par_err_q  <= 1'b0;
`endif
    end else begin
      rx_s1_q    <= rx_s1_d;
      rx_s2_q    <= rx_s2_d;
      rx_prev_q  <= rx_prev_d;
      div_cnt_q  <= div_cnt_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      data_q     <= data_d;
      baud_div_q <= baud_div_d;
      nbits_q    <= nbits_d;
      ovr_q      <= ovr_d;
`ifdef UART_RX_PARITY_EN
      par_en_q   <= par_en_d;
      par_odd_q  <= par_odd_d;
      par_err_q  <= par_err_d;
`endif
    end
  end

  uart_rx_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .arst_n (arst_n),
    .push   (push_s),
    .wdata  (wr_entry_s),
    .pop    (rd_en),
    .rdata  (rd_entry_s),
    .level  (fifo_level),
    .full   (fifo_full_s),
    .empty  (fifo_empty_s)
  );

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: frames are built bit by bit from a reference
// description, expected words queued at issue time and compared by a read monitor.
module tb_uart_rx_core;

  localparam int DATA_W   = 8;
  localparam int OVS      = 16;
  localparam int DEPTH    = 8;
  localparam int DIV_W    = 16;
  localparam int NB_W     = $clog2(DATA_W + 1);
  localparam int BAUD_DIV = 3;
  localparam int BIT_CLKS = (BAUD_DIV + 1) * OVS;

  logic                  clk = 1'b0;
  logic                  arst_n = 1'b0;
  logic                  rx = 1'b1;
  logic                  cfg_en = 1'b0;
  logic [DIV_W-1:0]      cfg_baud_div = DIV_W'(BAUD_DIV);
  logic [NB_W-1:0]       cfg_nbits = NB_W'(8);
  logic                  cfg_parity_en = 1'b0;
  logic                  cfg_parity_odd = 1'b0;
  logic                  rd_en;
  logic                  rd_valid;
  logic [DATA_W-1:0]     rd_data;
  logic                  rd_frame_err;
  logic                  rd_parity_err;
  logic [$clog2(DEPTH):0] fifo_level;
  logic                  overrun;
  logic                  ovr_clr = 1'b0;
  logic                  busy;

  uart_rx_core #(.DATA_W(DATA_W), .OVS(OVS), .DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .clk(clk), .arst_n(arst_n), .rx(rx), .cfg_en(cfg_en), .cfg_baud_div(cfg_baud_div),
    .cfg_nbits(cfg_nbits), .cfg_parity_en(cfg_parity_en), .cfg_parity_odd(cfg_parity_odd),
    .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data), .rd_frame_err(rd_frame_err),
    .rd_parity_err(rd_parity_err), .fifo_level(fifo_level), .overrun(overrun),
    .ovr_clr(ovr_clr), .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic              par;
    logic              frm;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  bit   auto_read = 1'b0;
  bit   exp_ovr = 1'b0;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Read monitor: pops the DUT whenever a word is shown and compares it with the scoreboard.
  initial begin
    exp_t e;
    rd_en = 1'b0;
    forever begin
      @(negedge clk);
      if (auto_read && arst_n && rd_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got data 0x%0h with empty scoreboard", rd_data);
        end else begin
          e = exp_q.pop_front();
          check("rd_data", 32'(rd_data), 32'(e.data));
          check("rd_frame_err", 32'(rd_frame_err), 32'(e.frm));
          check("rd_parity_err", 32'(rd_parity_err), 32'(e.par));
        end
        rd_en = 1'b1;
      end else begin
        rd_en = 1'b0;
      end
    end
  end

  // Model of the receive queue while nobody reads: a ninth word is lost and flags overrun.
  task automatic model_push(input exp_t e);
    if (!auto_read && exp_q.size() >= DEPTH) exp_ovr = 1'b1;
    else                                     exp_q.push_back(e);
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (BIT_CLKS) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] d, input int nb, input bit pen,
                            input bit podd, input bit pflip, input bit stop_v);
    int                eff;
    int                ones;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] dm;
    logic              pbit;
    exp_t              e;
    eff  = (nb < 5 || nb > DATA_W) ? DATA_W : nb;
    mask = DATA_W'((1 << eff) - 1);
    dm   = d & mask;
    ones = $countones(dm);
    pbit = ((ones % 2) == 0) ? podd : !podd;
    pbit = pbit ^ pflip;
    e.data = dm;
    e.frm  = !stop_v;
`ifdef UART_RX_PARITY_EN
    e.par  = pen && ((((ones + int'(pbit)) % 2) == 1) != podd);
`else
    e.par  = 1'b0;
`endif
    cfg_nbits      = NB_W'(nb);
    cfg_parity_en  = pen;
    cfg_parity_odd = podd;
    model_push(e);
    drive_bit(1'b0);
    for (int i = 0; i < eff; i++) drive_bit(dm[i]);
`ifdef UART_RX_PARITY_EN
    if (pen) drive_bit(pbit);
`endif
    drive_bit(stop_v);
    drive_bit(1'b1);
    drive_bit(1'b1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int   t0;
    int   lat;
    int   n;
    exp_t e;
    bit   pen;

    repeat (5) @(posedge clk);
    #1;
    check("reset_rd_valid", 32'(rd_valid), 32'd0);
    check("reset_fifo_level", 32'(fifo_level), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_rd_data", 32'(rd_data), 32'd0);
    check("reset_rd_frame_err", 32'(rd_frame_err), 32'd0);
    arst_n = 1'b1;
    cfg_en = 1'b1;
    auto_read = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    // 8N1 0xA5; the word should show up right after the middle of the stop bit (608 clk).
    t0 = int'(cyc);
    lat = 0;
    fork
      send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1);
      begin
        n = 0;
        while (!rd_valid && n < 2000) begin
          @(negedge clk);
          n++;
        end
        lat = int'(cyc) - t0;
      end
    join
    check_range("a5_latency", lat, 9 * BIT_CLKS + BIT_CLKS / 2, 9 * BIT_CLKS + BIT_CLKS / 2 + 6);
    wait_drain();

    auto_read = 1'b0;
    send_frame(8'h1F, 5, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'h15, 5, 1'b0, 1'b0, 1'b0, 1'b1);
    check("nbits5_level", 32'(fifo_level), 32'(exp_q.size()));
    auto_read = 1'b1;
    wait_drain();

`ifdef UART_RX_PARITY_EN
    send_frame(8'h03, 8, 1'b1, 1'b1, 1'b0, 1'b1);
    send_frame(8'h03, 8, 1'b1, 1'b1, 1'b1, 1'b1);
    send_frame(8'h5C, 6, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_drain();
`endif

    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_drain();

    // Short low pulse on an idle line must be rejected at the start-bit check.
    rx = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rx = 1'b1;
    check("glitch_busy_seen", 32'(busy), 32'd1);
    repeat (2 * BIT_CLKS) @(posedge clk);
    #1;
    check("glitch_busy_back", 32'(busy), 32'd0);
    check("glitch_no_push", 32'(fifo_level), 32'd0);

    auto_read = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) send_frame(DATA_W'($urandom), 8, 1'b0, 1'b0, 1'b0, 1'b1);
    check("ovr_level", 32'(fifo_level), 32'(exp_q.size()));
    check("ovr_set", 32'(overrun), 32'(exp_ovr));
    e = exp_q[0];
    check("ovr_head", 32'(rd_data), 32'(e.data));
    ovr_clr = 1'b1;
    @(posedge clk);
    #1;
    ovr_clr = 1'b0;
    exp_ovr = 1'b0;
    check("ovr_cleared", 32'(overrun), 32'(exp_ovr));
    auto_read = 1'b1;
    wait_drain();

    // Break: line low for longer than a whole frame, then a normal frame afterwards.
    e.data = '0;
    e.frm = 1'b1;
    e.par = 1'b0;
    cfg_nbits = NB_W'(8);
    cfg_parity_en = 1'b0;
    model_push(e);
    for (int i = 0; i < 12; i++) drive_bit(1'b0);
    check("break_idle", 32'(busy), 32'd0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_drain();

    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    cfg_en = 1'b0;
    rx = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("disable_busy", 32'(busy), 32'd0);
    repeat (2 * BIT_CLKS) @(posedge clk);
    #1;
    check("disable_no_push", 32'(fifo_level), 32'd0);
    cfg_en = 1'b1;
    send_frame(8'h66, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_drain();

    auto_read = 1'b0;
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    check("pre_reset_level", 32'(fifo_level), 32'(exp_q.size()));
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    arst_n = 1'b0;
    #2;
    exp_q.delete();
    check("arst_level", 32'(fifo_level), 32'(exp_q.size()));
    check("arst_rd_valid", 32'(rd_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    arst_n = 1'b1;
    drive_bit(1'b1);
    auto_read = 1'b1;
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_drain();

    for (int i = 0; i < 12; i++) begin
`ifdef UART_RX_PARITY_EN
      pen = 1'($urandom_range(0, 1));
`else
      pen = 1'b0;
`endif
      send_frame(DATA_W'($urandom), int'($urandom_range(3, 10)), pen, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 5) != 0));
    end
    wait_drain();

    check("final_overrun", 32'(overrun), 32'(exp_ovr));
    check("final_level", 32'(fifo_level), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
